// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - PC register, branch resolution, redirect flush, misaligned-target trap
// Decides taken/not-taken from comparator flags and owns the fetch PC and its trap state.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_imem_ready,
  input  logic             i_stall,
  input  logic             i_br_en,
  input  logic             i_jump,
  input  logic [2:0]       i_funct3,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  input  logic [31:0]      i_target,
  output logic             o_br_un,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc_four,
  output logic             o_taken,
  output logic             o_flush,
  output logic             o_trap,
  output logic [31:0]      o_trap_pc,
  output logic [CNT_W-1:0] o_taken_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

  state_t      state;
  logic        cond;
  logic [31:0] tgt;
  logic        misaligned;
  logic        adv;

  always_comb begin
    cond = 1'b0;
    case (i_funct3)
      3'b000:  cond = i_br_equal;
      3'b001:  cond = ~i_br_equal;
      3'b100:  cond = i_br_less;
      3'b101:  cond = ~i_br_less;
      3'b110:  cond = i_br_less;
      3'b111:  cond = ~i_br_less;
      default: cond = 1'b0;
    endcase
  end

  assign o_br_un    = i_funct3[1];
  assign o_pc_four  = o_pc + 32'd4;
  assign o_taken    = (state == RUN) & (i_jump | (i_br_en & cond));
  // bit 0 is always dropped (JALR rule); bit 1 set after that is a misaligned target
  assign tgt        = i_target & ~32'd1;
  assign misaligned = o_taken & tgt[1];
  assign adv        = ~i_stall & i_imem_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= BOOT;
      o_pc        <= RESET_PC;
      o_flush     <= 1'b0;
      o_trap      <= 1'b0;
      o_trap_pc   <= 32'd0;
      o_taken_cnt <= '0;
    end else begin
      o_flush <= 1'b0;
      case (state)
        BOOT: begin
          if (adv) begin
            o_pc  <= RESET_PC + 32'd4;
            state <= RUN;
          end
        end
        RUN: begin
          if (adv) begin
            if (misaligned) begin
              state     <= TRAP;
              o_trap    <= 1'b1;
              o_trap_pc <= o_pc;
            end else begin
              o_pc    <= o_taken ? tgt : o_pc_four;
              o_flush <= o_taken;
              if (o_taken)
                o_taken_cnt <= o_taken_cnt + CNT_W'(1);
            end
          end
        end
        TRAP: begin
          state <= TRAP;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed scoreboard bench for pc_branch_unit
// Expected register values are pushed when a step is driven and popped after the clock edge.
module tb_pc_branch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, imem_ready, stall, br_en, jump, br_less, br_equal;
  logic [2:0]  funct3;
  logic [31:0] target;
  logic        br_un, taken, flush, trap;
  logic [31:0] pc, pc_four, trap_pc;
  logic [3:0]  taken_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        flush;
    logic        trap;
    logic [31:0] trap_pc;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];

  // reference state: 0 = boot, 1 = run, 2 = trap
  int          m_st;
  logic [31:0] m_pc, m_trap_pc;
  logic        m_trap;
  logic [3:0]  m_cnt;

  pc_branch_unit #(.RESET_PC(RPC), .CNT_W(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_imem_ready(imem_ready), .i_stall(stall),
    .i_br_en(br_en), .i_jump(jump), .i_funct3(funct3), .i_br_less(br_less),
    .i_br_equal(br_equal), .i_target(target), .o_br_un(br_un), .o_pc(pc),
    .o_pc_four(pc_four), .o_taken(taken), .o_flush(flush), .o_trap(trap),
    .o_trap_pc(trap_pc), .o_taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick_and_score();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) return;
    e = q.pop_front();
    chk({e.tag, ".pc"}, pc, e.pc);
    chk({e.tag, ".pc_four"}, pc_four, e.pc + 32'd4);
    chk({e.tag, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
    chk({e.tag, ".trap"}, {31'd0, trap}, {31'd0, e.trap});
    chk({e.tag, ".trap_pc"}, trap_pc, e.trap_pc);
    chk({e.tag, ".cnt"}, {28'd0, taken_cnt}, {28'd0, e.cnt});
  endtask

  task automatic do_reset(input string tag, input logic st, input logic rdy);
    exp_t e;
    reset = 1'b1; stall = st; imem_ready = rdy;
    br_en = 1'b1; jump = 1'b1; funct3 = 3'b000; br_equal = 1'b1; br_less = 1'b1;
    target = 32'h0000_0303;
    m_st = 0; m_pc = RPC; m_trap = 1'b0; m_trap_pc = 32'd0; m_cnt = 4'd0;
    e = '{tag: tag, pc: RPC, flush: 1'b0, trap: 1'b0, trap_pc: 32'd0, cnt: 4'd0};
    q.push_back(e);
    tick_and_score();
    reset = 1'b0;
  endtask

  task automatic step(input string tag, input logic b, input logic j, input logic [2:0] f3,
                      input logic lt, input logic eq, input logic [31:0] tg,
                      input logic st, input logic rdy);
    logic        c, exp_taken, ok;
    logic [31:0] t;
    exp_t        e;
    br_en = b; jump = j; funct3 = f3; br_less = lt; br_equal = eq; target = tg;
    stall = st; imem_ready = rdy;
    #1;
    case (f3)
      3'b000: c = eq;
      3'b001: c = !eq;
      3'b100, 3'b110: c = lt;
      3'b101, 3'b111: c = !lt;
      default: c = 1'b0;
    endcase
    exp_taken = (m_st == 1) && (j || (b && c));
    chk({tag, ".taken"}, {31'd0, taken}, {31'd0, exp_taken});
    chk({tag, ".br_un"}, {31'd0, br_un}, {31'd0, f3[1]});
    ok = !st && rdy;
    e.flush = 1'b0;
    t = {tg[31:1], 1'b0};
    if (m_st == 0 && ok) begin
      m_pc = RPC + 32'd4; m_st = 1;
    end else if (m_st == 1 && ok) begin
      if (exp_taken && t[1]) begin
        m_st = 2; m_trap = 1'b1; m_trap_pc = m_pc;
      end else if (exp_taken) begin
        m_pc = t; e.flush = 1'b1; m_cnt = m_cnt + 4'd1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.tag = tag; e.pc = m_pc; e.trap = m_trap; e.trap_pc = m_trap_pc; e.cnt = m_cnt;
    q.push_back(e);
    tick_and_score();
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; br_en = 1'b0; jump = 1'b0;
    funct3 = 3'b000; br_less = 1'b0; br_equal = 1'b0; target = 32'd0;

    // boot holds while not ready, ignores branch inputs
    do_reset("rst0", 1'b0, 1'b0);
    step("boot_hold", 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 32'h0000_0800, 1'b0, 1'b0);
    step("boot_adv", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("boot_pc_104", pc, 32'h0000_0104);
    step("seq_108", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("seq_pc_108", pc, 32'h0000_0108);

    step("bltu_taken", 1'b1, 1'b0, 3'b110, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 1'b1);
    chk("bltu_pc_200", pc, 32'h0000_0200);
    chk("bltu_cnt_1", {28'd0, taken_cnt}, 32'd1);
    step("bge_fail", 1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 32'h0000_0600, 1'b0, 1'b1);
    step("f3_011", 1'b1, 1'b0, 3'b011, 1'b1, 1'b1, 32'h0000_0600, 1'b0, 1'b1);
    step("f3_010", 1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 32'h0000_0600, 1'b0, 1'b1);
    step("bne_nt", 1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 32'h0000_0600, 1'b0, 1'b1);
    step("bne_t", 1'b1, 1'b0, 3'b001, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 1'b1);
    step("blt_t", 1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 32'h0000_0340, 1'b0, 1'b1);
    step("bgeu_t", 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 32'h0000_0380, 1'b0, 1'b1);
    step("br_dis", 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_0600, 1'b0, 1'b1);
    step("jal_prio", 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 32'h0000_0500, 1'b0, 1'b1);
    step("after_jal", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // taken BEQ held by stall, then by not-ready, then commits once
    for (int i = 0; i < 3; i++)
      step("beq_stall", 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
    step("beq_both", 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b0);
    step("beq_nrdy", 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
    step("beq_go", 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b1);
    chk("beq_pc_400", pc, 32'h0000_0400);
    step("beq_b2b", 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_0421, 1'b0, 1'b1);
    step("flush_drop", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // PC wrap through 0xFFFF_FFFC
    step("jump_top", 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b1);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    step("pc_wrap", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("wrap_pc_0", pc, 32'h0000_0000);

    // counter wraps modulo 16
    for (int i = 0; i < 20 && m_cnt != 4'd0; i++)
      step("cnt_loop", 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0000_1000 + 32'(i) * 8, 1'b0, 1'b1);
    chk("cnt_wrap_0", {28'd0, taken_cnt}, 32'd0);

    // misaligned JALR target traps and freezes
    step("pre_trap", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step("jalr_303", 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0000_0303, 1'b0, 1'b1);
    chk("trap_set", {31'd0, trap}, 32'd1);
    for (int i = 0; i < 3; i++)
      step("trap_hold", 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 32'h0000_0700, 1'b0, 1'b1);
    do_reset("rst_trap", 1'b1, 1'b0);
    step("post_rst", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("post_rst_pc", pc, 32'h0000_0104);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
